// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the MEM/WB writeback sink.
//   DATA_W / ADDR_W : default data and register index widths
//   wb_state_t      : writeback handshake FSM state encoding
//   REG_ZERO        : index of the hard-wired zero register
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COMMIT = 2'b01,
    ACK    = 2'b10
  } wb_state_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with one write port and two combinational read ports.
//   clk, rst           : clock, asynchronous active-high reset (clears array)
//   we, waddr, wdata   : write port; writes to x0 are dropped
//   rs1_addr, rs2_addr : read addresses
//   rs1_data, rs2_data : read data; x0 reads 0, and a pending write
//                        (we high) to the addressed register is bypassed
module regfile_2r1w #(
  parameter int unsigned DATA_W   = pipeline_pkg::DATA_W,
  parameter int unsigned ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);
  import pipeline_pkg::*;

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (waddr != X0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rs1_data = mem[rs1_addr];
    if (rs1_addr == X0)                      rs1_data = '0;
    else if (we && (rs1_addr == waddr))      rs1_data = wdata;
  end

  always_comb begin
    rs2_data = mem[rs2_addr];
    if (rs2_addr == X0)                      rs2_data = '0;
    else if (we && (rs2_addr == waddr))      rs2_data = wdata;
  end

endmodule

// File: rtl/wb_regfile_sink.sv
// Consumer end of the MEM/WB writeback handshake.
//   clk, rst                     : clock, asynchronous active-high reset
//   i_data_ready/i_write_data/i_rd : level-held writeback request from MEM/WB
//   o_flush                      : ack to MEM/WB, high while in ACK
//   i_reserve, i_reserve_rd      : decoder marks a destination busy
//   i_rs1_addr/i_rs2_addr        : read addresses
//   o_rs1_data/o_rs2_data        : combinational read data (with commit bypass)
//   o_rs1_busy/o_rs2_busy        : scoreboard bit of the addressed register
//   o_wb_count                   : wrapping commit counter
//   o_error                      : sticky ACK timeout flag
//   o_debug_rd                   : last committed destination
module wb_regfile_sink #(
  parameter int unsigned DATA_W      = pipeline_pkg::DATA_W,
  parameter int unsigned ADDR_W      = pipeline_pkg::ADDR_W,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_data_ready,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [ADDR_W-1:0] i_rd,
  output logic              o_flush,
  input  logic              i_reserve,
  input  logic [ADDR_W-1:0] i_reserve_rd,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic [CNT_W-1:0]  o_wb_count,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_debug_rd
);
  import pipeline_pkg::*;

  localparam logic [ADDR_W-1:0] X0    = ADDR_W'(REG_ZERO);
  localparam int unsigned       TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMO   = TMR_W'(ACK_TIMEOUT);

  wb_state_t           state;
  logic [DATA_W-1:0]   lat_data;
  logic [ADDR_W-1:0]   lat_rd;
  logic [NUM_REGS-1:0] busy;
  logic [TMR_W-1:0]    timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_data   <= '0;
      lat_rd     <= '0;
      busy       <= '0;
      timer      <= '0;
      o_wb_count <= '0;
      o_debug_rd <= '0;
      o_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_data_ready) begin
            lat_data <= i_write_data;
            lat_rd   <= i_rd;
            state    <= COMMIT;
          end
        end
        COMMIT: begin
          if (lat_rd != X0) busy[lat_rd] <= 1'b0;
          o_wb_count <= o_wb_count + CNT_W'(1);
          o_debug_rd <= lat_rd;
          timer      <= '0;
          state      <= ACK;
        end
        ACK: begin
          // Timer saturates; the flag is raised on the edge it reaches the limit.
          if (timer != TMO) timer <= timer + TMR_W'(1);
          if (timer == TMO - TMR_W'(1)) o_error <= 1'b1;
          if (!i_data_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed after the commit clear so a same-cycle reserve of the same rd wins.
      if (i_reserve && (i_reserve_rd != X0)) busy[i_reserve_rd] <= 1'b1;
    end
  end

  assign o_flush    = (state == ACK);
  assign o_rs1_busy = (i_rs1_addr != X0) && busy[i_rs1_addr];
  assign o_rs2_busy = (i_rs2_addr != X0) && busy[i_rs2_addr];

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (state == COMMIT),
    .waddr    (lat_rd),
    .wdata    (lat_data),
    .rs1_addr (i_rs1_addr),
    .rs2_addr (i_rs2_addr),
    .rs1_data (o_rs1_data),
    .rs2_data (o_rs2_data)
  );

endmodule

// File: doc/wb_regfile_sink.md
Name: wb_regfile_sink

Overview:
Consumer end of the MEM/WB writeback handshake: accepts the memory stage's level-held data-ready, write data and destination register, commits them to the 32-entry register file, and returns the flush/ack that releases the memory stage's writeback register. It also provides two combinational read ports and a per-register busy scoreboard to the decoder.

Parameters:
DATA_W, 32, register and writeback data width
ADDR_W, 5, register index width
NUM_REGS, 32, register count; equals 2**ADDR_W
CNT_W, 16, width of the commit counter
ACK_TIMEOUT, 255, maximum ACK-state cycles before the sticky error is raised

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
i_data_ready  in  1  level from MEM/WB; high while the writeback register holds data
i_write_data  in  DATA_W  writeback data; stable while i_data_ready is high
i_rd  in  ADDR_W  writeback destination; stable while i_data_ready is high
o_flush  out  1  ack to MEM/WB; held high until i_data_ready falls
i_reserve  in  1  decoder issued an instruction that writes i_reserve_rd
i_reserve_rd  in  ADDR_W  register to mark busy
i_rs1_addr, i_rs2_addr  in  ADDR_W  read addresses
o_rs1_data, o_rs2_data  out  DATA_W  read data, combinational
o_rs1_busy, o_rs2_busy  out  1  scoreboard bit of the addressed register
o_wb_count  out  CNT_W  number of commits, wraps at 2**CNT_W
o_error  out  1  sticky; ACK timeout
o_debug_rd  out  ADDR_W  last committed rd

Behaviour:
- Reset (asynchronous, rst=1):
  - all registers, busy bits, o_wb_count, o_debug_rd, o_error and the ack timer are set to 0.
  - state is IDLE and o_flush is 0.
  - A reset mid-handshake drops o_flush immediately. Any captured value that has not been committed is discarded.
- FSM states are IDLE, COMMIT and ACK.
- IDLE:
  - o_flush=0.
  - If i_data_ready=1 at the edge, latch i_write_data and i_rd, then go to COMMIT.
- COMMIT:
  - At the edge, write the latched data to the latched rd. A write to rd=0 is dropped, so x0 always reads 0.
  - At the same edge: clear the busy bit of rd, increment o_wb_count (even when rd=0), set o_debug_rd=rd, clear the ack timer, and go to ACK.
- ACK:
  - o_flush=1, decoded from the state register (no combinational path from any input).
  - Go to IDLE at the first edge where i_data_ready=0.
  - The timer increments each cycle spent in ACK. When it reaches ACK_TIMEOUT, o_error is set to 1; the FSM stays in ACK.
- Latency: i_data_ready is sampled at edge N. The register write and ack assertion happen at edge N+1. o_flush falls one edge after i_data_ready is seen low.
- A new transaction is accepted only from IDLE. A level still high while in ACK is never re-captured; this is required because the producer lowers ready about 2 cycles after the flush.
- Read ports:
  - address 0 returns 0.
  - Otherwise the port returns the array contents. There is a bypass: when state is COMMIT and the address equals the latched rd (rd≠0), the port returns the latched data.
- Scoreboard:
  - i_reserve=1 with rd≠0 sets busy[rd] at the edge. Reserving x0 is ignored.
  - If a reserve and a commit target the same rd in the same cycle, the reserve wins and busy stays 1 (newer instruction).
  - o_rsN_busy is combinational from the busy array; x0 always reads 0.
- o_wb_count wraps from 2**CNT_W−1 to 0 with no flag.

Decomposition:
- Shared package (pipeline_pkg): DATA_W and ADDR_W constants, the writeback FSM state encoding (IDLE=2'b00, COMMIT=2'b01, ACK=2'b10), and the REG_ZERO constant.
- One sub-module, regfile_2r1w: array, x0 rule, write port, two read ports and the bypass.
- The handshake FSM, scoreboard, counter and timer stay in the top level.

Test Plan:
- Basic commit: hold i_data_ready=1, i_rd=5, i_write_data=0xDEADBEEF. Expect o_flush high after 2 edges and o_rs1_data(5)=0xDEADBEEF. Drop ready after 2 more cycles: o_flush=0 one edge later, o_wb_count=1, single commit only.
- x0 write: i_rd=0, data=0x1234. Expect o_rs1_data(0)=0, o_wb_count increments, and the handshake completes normally.
- Bypass: i_rs2_addr=7 during COMMIT of rd=7 with data 0xA5A5A5A5. Expect o_rs2_data=0xA5A5A5A5 in that cycle, before the array update.
- Scoreboard collision: reserve rd=3, then commit rd=3 with a same-cycle reserve rd=3. Expect o_rs1_busy(3)=1. A later commit with no reserve gives busy=0.
- Timeout: hold i_data_ready=1 for 300 cycles. Expect o_error=1 at cycle ACK_TIMEOUT into ACK, exactly one commit, and o_error still 1 after ready drops.
- Reset mid-ACK: assert rst while o_flush=1. Expect o_flush=0 immediately, all registers 0, o_wb_count=0, state IDLE; then a fresh transaction with rd=9 commits correctly.
